// File: rtl/jtag_dma_engine.sv
// DMA engine moving words between a ping-pong buffer half and a burst bus master port.
// Two-process FSM: registered state/bookkeeping, combinational next-state and all outputs.
module jtag_dma_engine (
  input  logic        system_clk,
  input  logic        reset,
  input  logic        launch_write,
  input  logic        launch_read,
  input  logic        launch_simple_switch,
  input  logic [31:0] address,
  input  logic [3:0]  byte_enable,
  input  logic [7:0]  burst_size,
  input  logic [7:0]  block_size,
  output logic        busy,
  output logic        operation_done,
  output logic        error,
  output logic [7:0]  block_size_out,
  output logic [8:0]  pp_address,
  output logic        pp_writeEnable,
  output logic [31:0] pp_dataIn,
  input  logic [31:0] pp_dataOut,
  output logic        bus_request,
  input  logic        bus_grant,
  output logic        begin_transaction,
  output logic [31:0] address_data_out,
  output logic        read_n_write,
  output logic [3:0]  byte_enable_out,
  output logic [7:0]  burst_size_out,
  output logic        data_valid_out,
  output logic        end_transaction,
  input  logic [31:0] address_data_in,
  input  logic        data_valid_in,
  input  logic        end_transaction_in,
  input  logic        bus_busy_in,
  input  logic        bus_error_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQUEST, S_BEGIN, S_WRITE_DATA, S_READ_DATA, S_END, S_DONE
  } state_e;

  typedef enum logic [1:0] {OP_WR, OP_RD, OP_SW} op_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [7:0]  burst;
    logic [7:0]  blk;
  } cmd_t;

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  cmd_t       cmd_q, cmd_d;
  logic [7:0] cnt_q, cnt_d;       // words completed, also the buffer index
  logic [7:0] beat_q, beat_d;     // beats completed in the current burst
  logic [7:0] bso_q, bso_d;       // beats-1 of the current burst
  logic [7:0] bso_out_q, bso_out_d;
  logic       busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [7:0] remaining, rem_m1, burst_len;
  logic [8:0] nxt_idx;
  logic       in_bus, bus_err, wr_beat, rd_beat;

  assign remaining = cmd_q.blk - cnt_q;
  assign rem_m1    = remaining - 8'd1;
  assign burst_len = (cmd_q.burst < rem_m1) ? cmd_q.burst : rem_m1;
  assign nxt_idx   = {1'b0, cnt_q} + 9'd1;
  assign in_bus    = state_q inside {S_REQUEST, S_BEGIN, S_WRITE_DATA, S_READ_DATA, S_END};
  assign bus_err   = in_bus && bus_error_in;
  assign wr_beat   = (state_q == S_WRITE_DATA) && !bus_busy_in && !bus_error_in;
  assign rd_beat   = (state_q == S_READ_DATA) && data_valid_in && !bus_error_in && (beat_q <= bso_q);

  assign busy           = busy_q;
  assign operation_done = done_q;
  assign error          = err_q;
  assign block_size_out = bso_out_q;

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_SW;
      cmd_q     <= '{addr: 32'd0, be: 4'hF, burst: 8'd0, blk: 8'd0};
      cnt_q     <= 8'd0;
      beat_q    <= 8'd0;
      bso_q     <= 8'd0;
      bso_out_q <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
      beat_q    <= beat_d;
      bso_q     <= bso_d;
      bso_out_q <= bso_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    beat_d    = beat_q;
    bso_d     = bso_q;
    bso_out_d = bso_out_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    bus_request       = 1'b0;
    begin_transaction = 1'b0;
    address_data_out  = 32'd0;
    read_n_write      = 1'b0;
    byte_enable_out   = 4'd0;
    burst_size_out    = 8'd0;
    data_valid_out    = 1'b0;
    end_transaction   = 1'b0;
    pp_address        = 9'd0;
    pp_writeEnable    = 1'b0;
    pp_dataIn         = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (launch_write || launch_read || launch_simple_switch) begin
          cmd_d  = '{addr: address, be: byte_enable, burst: burst_size, blk: block_size};
          cnt_d  = 8'd0;
          beat_d = 8'd0;
          busy_d = 1'b1;
          done_d = 1'b0;
          err_d  = 1'b0;
          if (launch_write)     op_d = OP_WR;
          else if (launch_read) op_d = OP_RD;
          else                  op_d = OP_SW;
          state_d = (!(launch_write || launch_read) || block_size == 8'd0) ? S_DONE : S_REQUEST;
        end
      end
      S_REQUEST: begin
        bus_request = 1'b1;
        if (bus_grant) state_d = S_BEGIN;
      end
      S_BEGIN: begin
        begin_transaction = 1'b1;
        address_data_out  = cmd_q.addr;
        read_n_write      = (op_q == OP_RD);
        byte_enable_out   = cmd_q.be;
        burst_size_out    = burst_len;
        bso_d             = burst_len;
        beat_d            = 8'd0;
        // Prefetch the first word so it is on pp_dataOut for the first beat.
        if (op_q == OP_WR) pp_address = {1'b0, cnt_q};
        state_d = (op_q == OP_RD) ? S_READ_DATA : S_WRITE_DATA;
      end
      S_WRITE_DATA: begin
        data_valid_out   = !bus_busy_in;
        address_data_out = bus_busy_in ? 32'd0 : pp_dataOut;
        // Hold the RAM address while stalled; move on only when a beat is taken.
        pp_address       = {1'b0, cnt_q};
        if (wr_beat) begin
          cnt_d  = cnt_q + 8'd1;
          beat_d = beat_q + 8'd1;
          if (nxt_idx < {1'b0, cmd_q.blk}) pp_address = nxt_idx;
          if (beat_q == bso_q) state_d = S_END;
        end
      end
      S_READ_DATA: begin
        if (rd_beat) begin
          pp_address     = {1'b0, cnt_q};
          pp_writeEnable = 1'b1;
          pp_dataIn      = address_data_in;
          cnt_d          = cnt_q + 8'd1;
          beat_d         = beat_q + 8'd1;
        end
        if (end_transaction_in) state_d = S_END;
      end
      S_END: begin
        end_transaction = (op_q == OP_WR);
        if (remaining != 8'd0) begin
          cmd_d.addr = cmd_q.addr + {22'd0, beat_q, 2'b00};
          state_d    = S_REQUEST;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (err_q) bso_out_d = cnt_q;
        else begin
          case (op_q)
            OP_WR:   bso_out_d = 8'd0;
            OP_RD:   bso_out_d = cnt_q;
            default: bso_out_d = bso_out_q;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A bus error in any bus state aborts the transfer and silences the bus at once.
    if (bus_err) begin
      state_d           = S_DONE;
      err_d             = 1'b1;
      bus_request       = 1'b0;
      begin_transaction = 1'b0;
      address_data_out  = 32'd0;
      read_n_write      = 1'b0;
      byte_enable_out   = 4'd0;
      burst_size_out    = 8'd0;
      data_valid_out    = 1'b0;
      end_transaction   = 1'b0;
    end
  end

endmodule

// File: doc/jtag_dma_engine.md
JTAG_DMA_ENGINE -- requirements
Module: jtag_dma_engine

Interface
REQ-001 SHALL have ports: system_clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 launch_write  in  1  one-cycle pulse: copy buffer half to memory.
REQ-004 launch_read  in  1  one-cycle pulse: copy memory into buffer half.
REQ-005 launch_simple_switch  in  1  one-cycle pulse: no transfer, completion only.
REQ-006 address  in  32  start byte address, word aligned; byte_enable  in  4; burst_size  in  8  beats-1 per burst; block_size  in  8  words to transfer.
REQ-007 busy  out  1;  operation_done  out  1  sticky;  error  out  1  sticky;  block_size_out  out  8  words valid in buffer half.
REQ-008 pp_address  out  9;  pp_writeEnable  out  1;  pp_dataIn  out  32;  pp_dataOut  in  32  (synchronous RAM, 1-cycle read latency).
REQ-009 Bus master: bus_request out 1; bus_grant in 1; begin_transaction out 1; address_data_out out 32; read_n_write out 1; byte_enable_out out 4; burst_size_out out 8; data_valid_out out 1; end_transaction out 1; address_data_in in 32; data_valid_in in 1; end_transaction_in in 1; bus_busy_in in 1; bus_error_in in 1.

Function
REQ-010 States: IDLE, REQUEST, BEGIN, WRITE_DATA, READ_DATA, END, DONE.
REQ-011 IDLE: on launch pulse latch address, byte_enable, burst_size, block_size; clear operation_done and error; set busy next cycle.
REQ-012 Simultaneous launch pulses SHALL be prioritised write > read > simple_switch; pulses while busy=1 SHALL be ignored.
REQ-013 simple_switch, or write/read with block_size=0, SHALL go IDLE->DONE with no bus activity; block_size_out unchanged for switch, 0 for zero-size read.
REQ-014 REQUEST: bus_request=1 until bus_grant=1, then BEGIN.
REQ-015 BEGIN: one cycle begin_transaction=1, address_data_out=current address, burst_size_out=min(burst_size, remaining-1), read_n_write=1 for read; then WRITE_DATA or READ_DATA.
REQ-016 WRITE_DATA: words read from buffer index 0..block_size-1 (pp_address={1'b0,index}); one word prefetched before first beat; data_valid_out=1 with data each cycle bus_busy_in=0; beat held while bus_busy_in=1.
REQ-017 READ_DATA: each data_valid_in=1 SHALL write address_data_in to pp_address={1'b0,index} with pp_writeEnable=1 same cycle, index+1.
REQ-018 Burst complete (beats = burst_size_out+1) -> END: write path drives end_transaction one cycle; read path waits end_transaction_in.
REQ-019 END: remaining>0 -> REQUEST with address += 4*(beats), modulo 2^32; remaining=0 -> DONE.
REQ-020 DONE: one cycle; operation_done=1, busy=0 next cycle; read sets block_size_out=words received; write sets block_size_out=0.
REQ-021 bus_error_in=1 in any bus state SHALL abort to DONE, deassert bus signals, set error=1; block_size_out=words completed.
REQ-022 Word counter 8-bit; block_size=255 SHALL transfer exactly 255 words without wrap; index never exceeds 254.
REQ-023 Bus outputs SHALL be 0 whenever not in the state driving them.

Reset
REQ-024 On reset: state IDLE, busy=0, operation_done=0, error=0, block_size_out=0, all bus and pp outputs 0, latched parameters 0 (byte_enable 4'hF).
REQ-025 Reset mid-transfer SHALL drop bus_request and all bus outputs asynchronously; no completion reported.

Verification
REQ-026 Read, address=0x100, block_size=4, burst_size=3, immediate grant -> one burst, 4 pp writes at index 0-3, block_size_out=4, operation_done=1.
REQ-027 Write, block_size=5, burst_size=1 -> bursts at 0x0/0x8/0x10 of 2,2,1 beats, buffer words 0-4 on bus in order, block_size_out=0.
REQ-028 launch_write and launch_read same cycle, then launch_read while busy -> only write executes; second pulse ignored.
REQ-029 bus_error_in during 2nd beat of read -> error=1, operation_done=1, block_size_out=1, bus_request=0.
REQ-030 block_size=255, burst_size=255 -> 255 beats, end at index 254, block_size_out=255; launch_simple_switch -> done in 2 cycles, no bus_request.
